// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection and fetch address.
// Branches and jumps are resolved from the ID-stage instruction with delay-slot semantics.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_EN,
    input  logic [31:0] instr_D,
    input  logic [31:0] a_PC_D,
    input  logic [31:0] rs_val_D,
    input  logic [31:0] rt_val_D,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] instr_I,
    output logic [31:0] a_PC_I,
    output logic        redirect_D,
    output logic        adel_F
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    logic [31:0] r_pc;

    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_d_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_im_end;
    logic signed [31:0] w_rs_s;
    logic        w_br_taken;
    logic        w_is_j;
    logic        w_is_jr;
    logic [31:0] w_npc;

    assign w_op         = instr_D[31:26];
    assign w_rt         = instr_D[20:16];
    assign w_funct      = instr_D[5:0];
    assign w_imm_sext   = {{16{instr_D[15]}}, instr_D[15:0]};
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_pc_d_plus4 = a_PC_D + 32'd4;
    assign w_br_target  = w_pc_d_plus4 + {w_imm_sext[29:0], 2'b00};
    assign w_j_target   = {w_pc_d_plus4[31:28], instr_D[25:0], 2'b00};
    assign w_rs_s       = signed'(rs_val_D);

    always_comb begin
        w_br_taken = 1'b0;
        unique case (w_op)
            OP_BEQ:    w_br_taken = (rs_val_D == rt_val_D);
            OP_BNE:    w_br_taken = (rs_val_D != rt_val_D);
            OP_BLEZ:   w_br_taken = (w_rs_s <= 0);
            OP_BGTZ:   w_br_taken = (w_rs_s > 0);
            OP_REGIMM: begin
                if (w_rt == RT_BLTZ) begin
                    w_br_taken = (w_rs_s < 0);
                end else if (w_rt == RT_BGEZ) begin
                    w_br_taken = (w_rs_s >= 0);
                end
            end
            default:   w_br_taken = 1'b0;
        endcase
    end

    assign w_is_j  = (w_op == OP_J) || (w_op == OP_JAL);
    assign w_is_jr = (w_op == OP_SPECIAL) && ((w_funct == FN_JR) || (w_funct == FN_JALR));

    always_comb begin
        w_npc = w_pc_plus4;
        if (w_br_taken) begin
            w_npc = w_br_target;
        end else if (w_is_j) begin
            w_npc = w_j_target;
        end else if (w_is_jr) begin
            // jr target is taken verbatim; misalignment surfaces later on adel_F
            w_npc = rs_val_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (IF_EN) begin
            r_pc <= w_npc;
        end
    end

    assign w_im_end    = IM_BASE + IM_SIZE;
    assign i_inst_addr = r_pc;
    assign a_PC_I      = r_pc;
    assign instr_I     = i_inst_rdata;
    assign redirect_D  = w_br_taken || w_is_j || w_is_jr;
    assign adel_F      = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc >= w_im_end);

endmodule
